// File: rtl/queen_pkg.sv
// Shared N-queens definitions: engine states, width helper and the default
// board geometry that both the search engine and the display block use.
package queen_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        EMIT  = 3'd2,
        BACK  = 3'd3,
        STEP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int DEFAULT_N     = 8;
    localparam int DEFAULT_W     = clog2(DEFAULT_N);
    localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/queen_conflict_check.sv
// Combinational attack test: does a queen at row 'candidate' in column 'col'
// share a row or a diagonal with any queen already placed to its left?
module queen_conflict_check
    import queen_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) (
    input  logic [N*W-1:0] rows,
    input  logic [W-1:0]   col,
    input  logic [W-1:0]   candidate,
    output logic           conflict
);

    logic [W-1:0] row_k;
    logic [W-1:0] row_gap;
    logic [W-1:0] col_gap;

    // Scan every column left of 'col' and flag a same-row or diagonal hit.
    always_comb begin
        conflict = 1'b0;
        row_k    = '0;
        row_gap  = '0;
        col_gap  = '0;
        for (int k = 0; k < N; k++) begin
            row_k   = rows[k*W +: W];
            row_gap = (row_k > candidate) ? (row_k - candidate) : (candidate - row_k);
            col_gap = col - W'(k);
            if (W'(k) < col) begin
                if ((row_k == candidate) || (row_gap == col_gap)) begin
                    conflict = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/queen_solver.sv
// Backtracking N-queens engine: one candidate is tested per clock, each
// complete board is offered on a valid/ready port, and accepted boards are
// counted with a saturating counter.
module queen_solver
    import queen_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sol_ready,
    output logic             busy,
    output logic             sol_valid,
    output logic [N*W-1:0]   solution,
    output logic [CNT_W-1:0] sol_count,
    output logic             done
);

    localparam logic [W-1:0]     LAST_IDX  = W'(N - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX = '1;

    state_t           state_q,     state_d;
    logic [W-1:0]     col_q,       col_d;
    logic [N*W-1:0]   rows_q,      rows_d;
    logic [N*W-1:0]   solution_q,  solution_d;
    logic [CNT_W-1:0] sol_count_q, sol_count_d;

    logic [W-1:0]     cur_row;
    logic [W-1:0]     next_col;
    logic             conflict;

    assign cur_row  = rows_q[int'(col_q)*W +: W];
    assign next_col = col_q + 1'b1;

    queen_conflict_check #(
        .N (N),
        .W (W)
    ) u_conflict (
        .rows      (rows_q),
        .col       (col_q),
        .candidate (cur_row),
        .conflict  (conflict)
    );

    // Next-state and datapath updates for the search walk.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        rows_d      = rows_q;
        solution_d  = solution_q;
        sol_count_d = sol_count_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    col_d          = '0;
                    rows_d[W-1:0]  = '0;
                    sol_count_d    = '0;
                    state_d        = CHECK;
                end
            end
            CHECK: begin
                if (!conflict) begin
                    if (col_q == LAST_IDX) begin
                        solution_d = rows_q;
                        state_d    = EMIT;
                    end else begin
                        col_d                           = next_col;
                        rows_d[int'(next_col)*W +: W]   = '0;
                    end
                end else if (cur_row != LAST_IDX) begin
                    rows_d[int'(col_q)*W +: W] = cur_row + 1'b1;
                end else begin
                    state_d = BACK;
                end
            end
            EMIT: begin
                if (sol_ready) begin
                    if (sol_count_q != COUNT_MAX) begin
                        sol_count_d = sol_count_q + 1'b1;
                    end
                    if (cur_row == LAST_IDX) begin
                        state_d = BACK;
                    end else begin
                        rows_d[int'(col_q)*W +: W] = cur_row + 1'b1;
                        state_d                    = CHECK;
                    end
                end
            end
            BACK: begin
                if (col_q == '0) begin
                    state_d = DONE;
                end else begin
                    col_d   = col_q - 1'b1;
                    state_d = STEP;
                end
            end
            STEP: begin
                if (cur_row == LAST_IDX) begin
                    state_d = BACK;
                end else begin
                    rows_d[int'(col_q)*W +: W] = cur_row + 1'b1;
                    state_d                    = CHECK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, board and counter registers; reset aborts any search in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            rows_q      <= '0;
            solution_q  <= '0;
            sol_count_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            rows_q      <= rows_d;
            solution_q  <= solution_d;
            sol_count_q <= sol_count_d;
        end
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign sol_valid = (state_q == EMIT);
    assign done      = (state_q == DONE);
    assign solution  = solution_q;
    assign sol_count = sol_count_q;

endmodule

// File: tb/tb_queen_solver.sv
// Directed bench for the N-queens engine: a 4x4 instance for ordering and
// restart behaviour, and two 8x8 instances for stall/reset and saturation.
module tb_queen_solver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8x8 instance, 8-bit counter
    logic        reset_a = 1'b1, start_a = 1'b0, ready_a = 1'b0;
    logic        busy_a, valid_a, done_a;
    logic [23:0] sol_a;
    logic [7:0]  cnt_a;

    // 4x4 instance, 8-bit counter
    logic        reset_b = 1'b1, start_b = 1'b0, ready_b = 1'b0;
    logic        busy_b, valid_b, done_b;
    logic [7:0]  sol_b;
    logic [7:0]  cnt_b;

    // 8x8 instance, 6-bit counter
    logic        reset_c = 1'b1, start_c = 1'b0, ready_c = 1'b0;
    logic        busy_c, valid_c, done_c;
    logic [23:0] sol_c;
    logic [5:0]  cnt_c;

    queen_solver #(.N(8), .W(3), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .sol_ready(ready_a),
        .busy(busy_a), .sol_valid(valid_a), .solution(sol_a),
        .sol_count(cnt_a), .done(done_a)
    );

    queen_solver #(.N(4), .W(2), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .sol_ready(ready_b),
        .busy(busy_b), .sol_valid(valid_b), .solution(sol_b),
        .sol_count(cnt_b), .done(done_b)
    );

    queen_solver #(.N(8), .W(3), .CNT_W(6)) dut_c (
        .clk(clk), .reset(reset_c), .start(start_c), .sol_ready(ready_c),
        .busy(busy_c), .sol_valid(valid_c), .solution(sol_c),
        .sol_count(cnt_c), .done(done_c)
    );

    int          first8_rows [8] = '{0, 4, 7, 5, 2, 6, 1, 3};
    logic [23:0] exp_first8;

    int          nsol_a, nsol_b, nsol_c;
    logic [23:0] first_a;
    logic [7:0]  sols_b [2];
    bit          timeout_a, timeout_b, timeout_c;

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One-cycle start pulse on the chosen instance (0=a, 1=b, 2=c).
    task automatic applyStimulus(input int which);
        @(posedge clk); #1;
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic run_a();
        nsol_a = 0; first_a = '0; timeout_a = 1'b1;
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk); #1;
            if (done_a) begin timeout_a = 1'b0; break; end
            if (valid_a && ready_a) begin
                if (nsol_a == 0) first_a = sol_a;
                nsol_a++;
            end
        end
    endtask

    task automatic run_b(input bit pulse_start);
        nsol_b = 0; sols_b[0] = '0; sols_b[1] = '0; timeout_b = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (done_b) begin start_b = 1'b0; timeout_b = 1'b0; break; end
            if (valid_b && ready_b) begin
                if (nsol_b < 2) sols_b[nsol_b] = sol_b;
                nsol_b++;
            end
            start_b = pulse_start && ((i % 4) == 1);
        end
        start_b = 1'b0;
    endtask

    task automatic run_c();
        nsol_c = 0; timeout_c = 1'b1;
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk); #1;
            if (done_c) begin timeout_c = 1'b0; break; end
            if (valid_c && ready_c) nsol_c++;
        end
    endtask

    initial begin
        exp_first8 = '0;
        for (int c = 0; c < 8; c++) begin
            exp_first8 = exp_first8 | (24'(first8_rows[c]) << (3 * c));
        end

        fork
            begin
                // 4x4: reset state, solution order and final count
                @(posedge clk); #1;
                checkOutput("b_reset_busy",  64'(busy_b),  64'd0);
                checkOutput("b_reset_valid", 64'(valid_b), 64'd0);
                checkOutput("b_reset_done",  64'(done_b),  64'd0);
                checkOutput("b_reset_count", 64'(cnt_b),   64'd0);
                checkOutput("b_reset_sol",   64'(sol_b),   64'd0);
                reset_b = 1'b0;
                ready_b = 1'b1;
                applyStimulus(1);
                checkOutput("b_busy_after_start", 64'(busy_b), 64'd1);
                run_b(1'b0);
                checkOutput("b_timeout", 64'(timeout_b), 64'd0);
                checkOutput("b_sol0",    64'(sols_b[0]), 64'h8D);
                checkOutput("b_sol1",    64'(sols_b[1]), 64'h72);
                checkOutput("b_nsol",    64'(nsol_b),    64'd2);
                checkOutput("b_count",   64'(cnt_b),     64'd2);
                checkOutput("b_done",    64'(done_b),    64'd1);
                checkOutput("b_idle_busy", 64'(busy_b),  64'd0);

                // 4x4: restart after done, with stray start pulses while busy
                applyStimulus(1);
                checkOutput("b_restart_done",  64'(done_b), 64'd0);
                checkOutput("b_restart_count", 64'(cnt_b),  64'd0);
                checkOutput("b_restart_busy",  64'(busy_b), 64'd1);
                run_b(1'b1);
                checkOutput("b2_timeout", 64'(timeout_b), 64'd0);
                checkOutput("b2_sol0",    64'(sols_b[0]), 64'h8D);
                checkOutput("b2_sol1",    64'(sols_b[1]), 64'h72);
                checkOutput("b2_nsol",    64'(nsol_b),    64'd2);
                checkOutput("b2_count",   64'(cnt_b),     64'd2);
                checkOutput("b2_done",    64'(done_b),    64'd1);

                // 8x8: stall at the first solution
                reset_a = 1'b0;
                ready_a = 1'b0;
                applyStimulus(0);
                timeout_a = 1'b1;
                for (int i = 0; i < 5000; i++) begin
                    if (valid_a) begin timeout_a = 1'b0; break; end
                    @(posedge clk); #1;
                end
                checkOutput("a_first_valid_timeout", 64'(timeout_a), 64'd0);
                checkOutput("a_stall_sol", 64'(sol_a), 64'(exp_first8));
                begin
                    bit stable;
                    stable = 1'b1;
                    for (int i = 0; i < 20; i++) begin
                        @(posedge clk); #1;
                        if (sol_a !== exp_first8 || valid_a !== 1'b1) stable = 1'b0;
                    end
                    checkOutput("a_stall_stable", 64'(stable), 64'd1);
                end
                checkOutput("a_stall_count", 64'(cnt_a), 64'd0);
                checkOutput("a_stall_busy",  64'(busy_a), 64'd1);
                ready_a = 1'b1;
                @(posedge clk); #1;
                checkOutput("a_release_count", 64'(cnt_a),   64'd1);
                checkOutput("a_release_valid", 64'(valid_a), 64'd0);

                // 8x8: reset while checking candidates
                reset_a = 1'b1;
                @(posedge clk); #1;
                reset_a = 1'b0;
                checkOutput("a_abort_busy",  64'(busy_a),  64'd0);
                checkOutput("a_abort_valid", 64'(valid_a), 64'd0);
                checkOutput("a_abort_done",  64'(done_a),  64'd0);
                checkOutput("a_abort_count", 64'(cnt_a),   64'd0);
                checkOutput("a_abort_sol",   64'(sol_a),   64'd0);
                repeat (1) @(posedge clk);
                #1;

                // 8x8: full search after the abort
                applyStimulus(0);
                run_a();
                checkOutput("a_timeout", 64'(timeout_a), 64'd0);
                checkOutput("a_first",   64'(first_a),   64'(exp_first8));
                checkOutput("a_nsol",    64'(nsol_a),    64'd92);
                checkOutput("a_count",   64'(cnt_a),     64'd92);
                checkOutput("a_done",    64'(done_a),    64'd1);
                checkOutput("a_busy",    64'(busy_a),    64'd0);
            end
            begin
                // 8x8 with a 6-bit counter: saturation
                @(posedge clk); #1;
                reset_c = 1'b0;
                ready_c = 1'b1;
                applyStimulus(2);
                run_c();
                checkOutput("c_timeout", 64'(timeout_c), 64'd0);
                checkOutput("c_nsol",    64'(nsol_c),    64'd92);
                checkOutput("c_count",   64'(cnt_c),     64'd63);
                checkOutput("c_done",    64'(done_c),    64'd1);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
